countdown_timer_64bit: RTL and testbench

//  Loadable down-counting timer, the counterpart of the up-counter: counts a loaded value down to zero.

---
 rtl/countdown_timer_64bit.sv | 115 +++++++++++
 tb/tb_countdown_timer_64bit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_64bit.sv
// Loadable down-counting timer with run/pause FSM, tick prescaler and zero floor.
// Optional periodic mode: define AUTO_RELOAD_EN to reload the last loaded value on expiry.
module countdown_timer_64bit #(
  parameter int WIDTH     = 64,
  parameter int PRE_WIDTH = 8,
  parameter int PRESCALE  = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CLEAR,
  input  logic             LOAD_EN,
  input  logic [WIDTH-1:0] LOAD_DATA,
  input  logic             START,
  input  logic             STOP,
  input  logic             COUNT_EN,
  output logic [WIDTH-1:0] Q_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             ZERO
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  localparam logic [PRE_WIDTH-1:0] PRE_LAST = PRE_WIDTH'(PRESCALE - 1);

  state_t               r_state;
  logic [WIDTH-1:0]     r_q;
  logic [PRE_WIDTH-1:0] r_pre;
  logic                 r_done;
  logic [WIDTH-1:0]     w_reload;
  logic                 w_tick;
  logic                 w_preWrap;
  logic                 w_lastCount;

`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_reload <= '0;
    end else if (CLEAR) begin
      r_reload <= '0;
    end else if (LOAD_EN) begin
      r_reload <= LOAD_DATA;
    end
  end

  assign w_reload = r_reload;
`else
  assign w_reload = '0;
`endif

  assign w_tick      = (r_state == S_RUN) && COUNT_EN;
  assign w_preWrap   = (r_pre == PRE_LAST);
  assign w_lastCount = (r_q == WIDTH'(1));

  // A zero reload value (always the case without AUTO_RELOAD_EN) parks the timer in EXPIRED.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_pre   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (CLEAR) begin
        r_state <= S_IDLE;
        r_q     <= '0;
        r_pre   <= '0;
      end else if (LOAD_EN) begin
        r_q   <= LOAD_DATA;
        r_pre <= '0;
        if (r_state == S_EXPIRED) begin
          r_state <= S_IDLE;
        end else if (r_state == S_RUN && LOAD_DATA == '0) begin
          r_state <= S_IDLE;
        end
      end else if (STOP && r_state == S_RUN) begin
        r_state <= S_PAUSED;
      end else if (START && (r_state == S_IDLE || r_state == S_PAUSED)) begin
        if (r_q != '0) begin
          r_state <= S_RUN;
        end
      end else if (w_tick && !STOP) begin
        if (!w_preWrap) begin
          r_pre <= r_pre + PRE_WIDTH'(1);
        end else begin
          r_pre <= '0;
          if (w_lastCount) begin
            r_done <= 1'b1;
            if (w_reload != '0) begin
              r_q <= w_reload;
            end else begin
              r_q     <= '0;
              r_state <= S_EXPIRED;
            end
          end else if (r_q != '0) begin
            r_q <= r_q - WIDTH'(1);
          end
        end
      end
    end
  end

  assign Q_OUT = r_q;
  assign BUSY  = (r_state == S_RUN);
  assign DONE  = r_done;
  assign ZERO  = (r_q == '0);

endmodule

// File: tb/tb_countdown_timer_64bit.sv
// Bench for countdown_timer_64bit: one instance with PRESCALE=1, one with PRESCALE=4.
// The periodic sequence is exercised only when AUTO_RELOAD_EN is defined.
module tb_countdown_timer_64bit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        clear = 1'b0;
  logic        loadEn = 1'b0;
  logic [63:0] loadData = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        countEn = 1'b0;

  logic [63:0] q1, q4;
  logic        busy1, busy4, done1, done4, zero1, zero4;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic        clr;
    logic        ld;
    logic [63:0] data;
    logic        stp;
    logic        sta;
    logic        cen;
    logic [63:0] q;
    logic        busy;
    logic        done;
  } vec_t;

  typedef struct {
    logic [63:0] q;
    logic        busy;
    logic        done;
    logic        zero;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];

  countdown_timer_64bit #(.WIDTH(64), .PRE_WIDTH(8), .PRESCALE(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .CLEAR(clear), .LOAD_EN(loadEn), .LOAD_DATA(loadData),
    .START(start), .STOP(stop), .COUNT_EN(countEn),
    .Q_OUT(q1), .BUSY(busy1), .DONE(done1), .ZERO(zero1)
  );

  countdown_timer_64bit #(.WIDTH(64), .PRE_WIDTH(8), .PRESCALE(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .CLEAR(clear), .LOAD_EN(loadEn), .LOAD_DATA(loadData),
    .START(start), .STOP(stop), .COUNT_EN(countEn),
    .Q_OUT(q4), .BUSY(busy4), .DONE(done4), .ZERO(zero4)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(logic clr, logic ld, logic [63:0] data, logic stp, logic sta,
                              logic cen, logic [63:0] q, logic busy, logic done);
    vec_t v;
    v.clr = clr; v.ld = ld; v.data = data; v.stp = stp; v.sta = sta; v.cen = cen;
    v.q = q; v.busy = busy; v.done = done;
    return v;
  endfunction

  task automatic cmp(input string tag, input logic [63:0] act, input logic [63:0] req);
    checkCount++;
    if (act === req) passCount++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", tag, act, req);
  endtask

  task automatic checkOutput(input bit sel4, input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      checkCount++;
      $display("[TB] FAIL %s: actual=empty-scoreboard required=entry", tag);
    end else begin
      e = sbq.pop_front();
      cmp({tag, ".q"},    sel4 ? q4 : q1,                 e.q);
      cmp({tag, ".busy"}, 64'(sel4 ? busy4 : busy1),      64'(e.busy));
      cmp({tag, ".done"}, 64'(sel4 ? done4 : done1),      64'(e.done));
      cmp({tag, ".zero"}, 64'(sel4 ? zero4 : zero1),      64'(e.zero));
    end
  endtask

  task automatic applyStimulus(input vec_t v, input bit sel4, input string tag);
    exp_t e;
    @(negedge CLK);
    clear = v.clr; loadEn = v.ld; loadData = v.data;
    stop = v.stp; start = v.sta; countEn = v.cen;
    e.q = v.q; e.busy = v.busy; e.done = v.done; e.zero = (v.q == '0);
    sbq.push_back(e);
    @(posedge CLK);
    #1;
    checkOutput(sel4, tag);
  endtask

  task automatic step(input logic clr, input logic ld, input logic [63:0] data, input logic stp,
                      input logic sta, input logic cen, input logic [63:0] q, input logic busy,
                      input logic done, input bit sel4, input string tag);
    applyStimulus(mk(clr, ld, data, stp, sta, cen, q, busy, done), sel4, tag);
  endtask

  initial begin
    // clr ld data stp sta cen | q busy done
    vecs.push_back(mk(0,1,64'd5, 0,0,0, 64'd5, 0,0));
    vecs.push_back(mk(0,0,64'd0, 0,1,1, 64'd5, 1,0));
    vecs.push_back(mk(0,0,64'd0, 0,0,1, 64'd4, 1,0));
    vecs.push_back(mk(0,0,64'd0, 0,0,1, 64'd3, 1,0));
    vecs.push_back(mk(0,0,64'd0, 0,0,1, 64'd2, 1,0));
    vecs.push_back(mk(0,0,64'd0, 0,0,1, 64'd1, 1,0));
    vecs.push_back(mk(0,0,64'd0, 0,0,1, 64'd0, 0,1));
    vecs.push_back(mk(0,0,64'd0, 0,0,1, 64'd0, 0,0));
    vecs.push_back(mk(0,0,64'd0, 0,1,1, 64'd0, 0,0));
    vecs.push_back(mk(0,1,64'd10,0,0,0, 64'd10,0,0));
    vecs.push_back(mk(0,0,64'd0, 0,1,1, 64'd10,1,0));
    vecs.push_back(mk(0,0,64'd0, 0,0,1, 64'd9, 1,0));
    vecs.push_back(mk(0,0,64'd0, 0,0,1, 64'd8, 1,0));
    vecs.push_back(mk(0,0,64'd0, 0,0,1, 64'd7, 1,0));
    vecs.push_back(mk(0,0,64'd0, 1,0,1, 64'd7, 0,0));
    vecs.push_back(mk(0,0,64'd0, 1,0,1, 64'd7, 0,0));
    vecs.push_back(mk(0,0,64'd0, 1,0,1, 64'd7, 0,0));
    vecs.push_back(mk(0,0,64'd0, 0,0,1, 64'd7, 0,0));
    vecs.push_back(mk(0,0,64'd0, 0,1,1, 64'd7, 1,0));
    vecs.push_back(mk(0,0,64'd0, 0,0,1, 64'd6, 1,0));
    vecs.push_back(mk(0,0,64'd0, 0,0,1, 64'd5, 1,0));
    vecs.push_back(mk(0,0,64'd0, 1,1,1, 64'd5, 0,0));
    vecs.push_back(mk(0,0,64'd0, 0,1,0, 64'd5, 1,0));
    vecs.push_back(mk(0,1,64'd0, 0,0,1, 64'd0, 0,0));
    vecs.push_back(mk(0,0,64'd0, 0,0,1, 64'd0, 0,0));
    vecs.push_back(mk(0,0,64'd0, 0,1,1, 64'd0, 0,0));
    vecs.push_back(mk(0,1,64'd9, 0,0,0, 64'd9, 0,0));
    vecs.push_back(mk(0,0,64'd0, 0,1,0, 64'd9, 1,0));
    vecs.push_back(mk(1,1,64'd20,0,0,1, 64'd0, 0,0));
    vecs.push_back(mk(0,0,64'd0, 0,1,1, 64'd0, 0,0));
    vecs.push_back(mk(0,1,64'd3, 0,0,0, 64'd3, 0,0));
    vecs.push_back(mk(0,0,64'd0, 0,1,1, 64'd3, 1,0));
    vecs.push_back(mk(0,0,64'd0, 0,0,1, 64'd2, 1,0));
    vecs.push_back(mk(0,1,64'd4, 0,0,1, 64'd4, 1,0));
    vecs.push_back(mk(0,0,64'd0, 0,0,1, 64'd3, 1,0));
    vecs.push_back(mk(1,0,64'd0, 0,0,1, 64'd0, 0,0));
    vecs.push_back(mk(0,1,64'hFFFF_FFFF_FFFF_FFFF, 0,0,0, 64'hFFFF_FFFF_FFFF_FFFF, 0,0));
    vecs.push_back(mk(0,0,64'd0, 0,1,1, 64'hFFFF_FFFF_FFFF_FFFF, 1,0));
    vecs.push_back(mk(0,0,64'd0, 0,0,1, 64'hFFFF_FFFF_FFFF_FFFE, 1,0));
    vecs.push_back(mk(1,0,64'd0, 0,0,0, 64'd0, 0,0));

    #3;
    cmp("rst1.q", q1, 64'd0);
    cmp("rst1.zero", 64'(zero1), 64'd1);
    cmp("rst4.busy", 64'(busy4), 64'd0);
    cmp("rst4.done", 64'(done4), 64'd0);
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], 1'b0, $sformatf("vec%0d", i));
    end

    step(1,0,64'd0, 0,0,0, 64'd0, 0,0, 1'b1, "pre.clr");
    step(0,1,64'd2, 0,0,0, 64'd2, 0,0, 1'b1, "pre.load");
    step(0,0,64'd0, 0,1,1, 64'd2, 1,0, 1'b1, "pre.start");
    for (int k = 1; k <= 8; k++) begin
      if (k == 6) begin
        step(0,0,64'd0, 0,0,0, 64'd1, 1,0, 1'b1, "pre.gapA");
        step(0,0,64'd0, 0,0,0, 64'd1, 1,0, 1'b1, "pre.gapB");
      end
      step(0,0,64'd0, 0,0,1, (k < 4) ? 64'd2 : (k < 8) ? 64'd1 : 64'd0,
           logic'(k < 8), logic'(k == 8), 1'b1, $sformatf("pre.tick%0d", k));
    end
    step(0,0,64'd0, 0,0,1, 64'd0, 0,0, 1'b1, "pre.after");

    step(1,0,64'd0, 0,0,0, 64'd0, 0,0, 1'b0, "mid.clr");
    step(0,1,64'd40,0,0,0, 64'd40,0,0, 1'b0, "mid.load");
    step(0,0,64'd0, 0,1,1, 64'd40,1,0, 1'b0, "mid.start");
    step(0,0,64'd0, 0,0,1, 64'd39,1,0, 1'b0, "mid.t1");
    step(0,0,64'd0, 0,0,1, 64'd38,1,0, 1'b0, "mid.t2");
    step(0,0,64'd0, 0,0,1, 64'd37,1,0, 1'b0, "mid.t3");
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    cmp("async.q", q1, 64'd0);
    cmp("async.busy", 64'(busy1), 64'd0);
    cmp("async.done", 64'(done1), 64'd0);
    cmp("async.zero", 64'(zero1), 64'd1);
    @(negedge CLK);
    RESET = 1'b0;
    step(0,0,64'd0, 0,0,1, 64'd0, 0,0, 1'b0, "async.idle");

`ifdef AUTO_RELOAD_EN
    step(1,0,64'd0, 0,0,0, 64'd0, 0,0, 1'b0, "ar.clr");
    step(0,1,64'd3, 0,0,0, 64'd3, 0,0, 1'b0, "ar.load");
    step(0,0,64'd0, 0,1,1, 64'd3, 1,0, 1'b0, "ar.start");
    step(0,0,64'd0, 0,0,1, 64'd2, 1,0, 1'b0, "ar.c2");
    step(0,0,64'd0, 0,0,1, 64'd1, 1,0, 1'b0, "ar.c1");
    step(0,0,64'd0, 0,0,1, 64'd3, 1,1, 1'b0, "ar.reload1");
    step(0,0,64'd0, 0,0,1, 64'd2, 1,0, 1'b0, "ar.c2b");
    step(0,0,64'd0, 0,0,1, 64'd1, 1,0, 1'b0, "ar.c1b");
    step(0,0,64'd0, 0,0,1, 64'd3, 1,1, 1'b0, "ar.reload2");
`endif

    if (sbq.size() != 0) begin
      checkCount++;
      $display("[TB] FAIL scoreboard.drain: actual=%0d required=0", sbq.size());
    end
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
